// File: rtl/mux_select_arbiter_pkg.sv
// rtl/mux_select_arbiter_pkg.sv - shared state and select encodings for the 2:1 mux arbiter
package mux_select_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_GRANT1 = 2'd1,
      ST_GRANT2 = 2'd2
   } arb_state_t;

   localparam logic SEL_D1 = 1'b0;
   localparam logic SEL_D2 = 1'b1;

endpackage

// File: rtl/mux_beat_counter.sv
// rtl/mux_beat_counter.sv - beat counter with sync clear, enable and terminal-count flag
module mux_beat_counter #(
   parameter int BURST_LEN = 4,
   parameter int CNT_W     = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   output logic [CNT_W-1:0] cnt,
   output logic             tc
);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign tc = (cnt == CNT_W'(BURST_LEN - 1));

endmodule

// File: rtl/mux_select_arbiter.sv
// rtl/mux_select_arbiter.sv - round-robin burst-locked arbiter driving the 2:1 mux select
module mux_select_arbiter
   import mux_select_arbiter_pkg::*;
#(
   parameter int BURST_LEN = 4,
   parameter int CNT_W     = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             REQ1,
   input  logic             REQ2,
   input  logic             READY,
   output logic             S,
   output logic             GNT1,
   output logic             GNT2,
   output logic             BEAT,
   output logic [CNT_W-1:0] BCNT
);

   arb_state_t state, state_nxt;
   logic       last, last_nxt;     // 0: channel 1 served last, 1: channel 2
   logic       s_nxt;
   logic       cnt_clr, cnt_en, tc;
   logic       own_req, other_req, rel;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= ST_IDLE;
         last  <= 1'b1;
         S     <= SEL_D1;
      end else begin
         state <= state_nxt;
         last  <= last_nxt;
         S     <= s_nxt;
      end
   end

   assign GNT1 = (state == ST_GRANT1);
   assign GNT2 = (state == ST_GRANT2);
   assign BEAT = ((GNT1 & REQ1) | (GNT2 & REQ2)) & READY;

   always_comb begin
      state_nxt = state;
      last_nxt  = last;
      cnt_clr   = 1'b0;
      cnt_en    = 1'b0;
      own_req   = 1'b0;
      other_req = 1'b0;
      rel       = 1'b0;
      case (state)
         ST_IDLE: begin
            if (REQ1 && REQ2)
               state_nxt = last ? ST_GRANT1 : ST_GRANT2;
            else if (REQ1)
               state_nxt = ST_GRANT1;
            else if (REQ2)
               state_nxt = ST_GRANT2;
         end
         ST_GRANT1, ST_GRANT2: begin
            own_req   = (state == ST_GRANT1) ? REQ1 : REQ2;
            other_req = (state == ST_GRANT1) ? REQ2 : REQ1;
            // A dropped request releases immediately without counting a beat.
            rel       = (BEAT && tc) || !own_req;
            if (rel) begin
               cnt_clr  = 1'b1;
               last_nxt = (state == ST_GRANT2);
               if (other_req)
                  state_nxt = (state == ST_GRANT1) ? ST_GRANT2 : ST_GRANT1;
               else if (!own_req)
                  state_nxt = ST_IDLE;
            end else begin
               cnt_en = BEAT;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase

      case (state_nxt)
         ST_GRANT1: s_nxt = SEL_D1;
         ST_GRANT2: s_nxt = SEL_D2;
         default:   s_nxt = S;
      endcase
   end

   mux_beat_counter #(
      .BURST_LEN (BURST_LEN),
      .CNT_W     (CNT_W)
   ) u_beat_counter (
      .clk (CLK),
      .rst (RST),
      .clr (cnt_clr),
      .en  (cnt_en),
      .cnt (BCNT),
      .tc  (tc)
   );

endmodule

// File: tb/tb_mux_select_arbiter.sv
// tb/tb_mux_select_arbiter.sv - self-checking bench for mux_select_arbiter (BURST_LEN 4 and 1)
module tb_mux_select_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, req1, req2, ready;
   logic       s_a, gnt1_a, gnt2_a, beat_a;
   logic [7:0] bcnt_a;
   logic       s_b, gnt1_b, gnt2_b, beat_b;
   logic [7:0] bcnt_b;

   int checks   = 0;
   int failures = 0;

   // Reference model: owner 0=none,1=ch1,2=ch2; index 0 -> BURST_LEN 4, 1 -> BURST_LEN 1.
   int m_own[2];
   int m_cnt[2];
   int m_last[2];
   int m_sel[2];
   int bl[2];

   mux_select_arbiter #(.BURST_LEN(4), .CNT_W(8)) dut_a (
      .CLK(clk), .RST(rst), .REQ1(req1), .REQ2(req2), .READY(ready),
      .S(s_a), .GNT1(gnt1_a), .GNT2(gnt2_a), .BEAT(beat_a), .BCNT(bcnt_a)
   );

   mux_select_arbiter #(.BURST_LEN(1), .CNT_W(8)) dut_b (
      .CLK(clk), .RST(rst), .REQ1(req1), .REQ2(req2), .READY(ready),
      .S(s_b), .GNT1(gnt1_b), .GNT2(gnt2_b), .BEAT(beat_b), .BCNT(bcnt_b)
   );

   function automatic logic m_beat(int k);
      return ((m_own[k] == 1 && req1) || (m_own[k] == 2 && req2)) && ready;
   endfunction

   task automatic drive(input logic r, input logic a, input logic b, input logic rdy);
      rst = r; req1 = a; req2 = b; ready = rdy;
      #1;
   endtask

   task automatic tick();
      int  other;
      logic mine, oth, bt;
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            m_own[k] = 0; m_cnt[k] = 0; m_last[k] = 2; m_sel[k] = 0;
         end else if (m_own[k] == 0) begin
            if (req1 && req2) m_own[k] = (m_last[k] == 1) ? 2 : 1;
            else if (req1)    m_own[k] = 1;
            else if (req2)    m_own[k] = 2;
         end else begin
            mine  = (m_own[k] == 1) ? req1 : req2;
            oth   = (m_own[k] == 1) ? req2 : req1;
            other = 3 - m_own[k];
            bt    = mine && ready;
            if ((bt && (m_cnt[k] + 1 == bl[k])) || !mine) begin
               m_last[k] = m_own[k];
               m_cnt[k]  = 0;
               if (oth)        m_own[k] = other;
               else if (!mine) m_own[k] = 0;
            end else if (bt) begin
               m_cnt[k] = m_cnt[k] + 1;
            end
         end
         if (m_own[k] != 0) m_sel[k] = m_own[k] - 1;
      end
      #1;
   endtask

   task automatic test_reset();
      drive(1, 0, 0, 0); tick(); tick();
      checks++;
      if (s_a !== 1'b0 || gnt1_a !== 1'b0 || gnt2_a !== 1'b0 || bcnt_a !== 8'd0) begin
         failures++;
         $display("FAIL reset_a: got S=%0d G1=%0d G2=%0d BCNT=%0d expected 0 0 0 0", s_a, gnt1_a, gnt2_a, bcnt_a);
      end
      checks++;
      if (s_b !== 1'b0 || gnt1_b !== 1'b0 || gnt2_b !== 1'b0 || bcnt_b !== 8'd0) begin
         failures++;
         $display("FAIL reset_b: got S=%0d G1=%0d G2=%0d BCNT=%0d expected 0 0 0 0", s_b, gnt1_b, gnt2_b, bcnt_b);
      end
   endtask

   task automatic test_first_tie();
      drive(0, 1, 1, 1); tick();
      checks++;
      if (gnt1_a !== 1'b1 || gnt2_a !== 1'b0 || s_a !== 1'b0) begin
         failures++;
         $display("FAIL first_tie: got G1=%0d G2=%0d S=%0d expected 1 0 0", gnt1_a, gnt2_a, s_a);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (beat_a !== 1'b1) begin
            failures++;
            $display("FAIL tie_beat%0d: got %0d expected 1", i, beat_a);
         end
         tick();
         if (i < 3) begin
            checks++;
            if (gnt1_a !== 1'b1 || bcnt_a !== 8'(i + 1)) begin
               failures++;
               $display("FAIL tie_hold%0d: got G1=%0d BCNT=%0d expected 1 %0d", i, gnt1_a, bcnt_a, i + 1);
            end
         end
      end
      checks++;
      if (gnt2_a !== 1'b1 || gnt1_a !== 1'b0 || s_a !== 1'b1 || bcnt_a !== 8'd0) begin
         failures++;
         $display("FAIL tie_handoff: got G1=%0d G2=%0d S=%0d BCNT=%0d expected 0 1 1 0", gnt1_a, gnt2_a, s_a, bcnt_a);
      end
   endtask

   task automatic test_backpressure();
      drive(1, 0, 0, 0); tick();
      drive(0, 1, 0, 1); tick(); tick(); tick();
      checks++;
      if (gnt1_a !== 1'b1 || bcnt_a !== 8'd2) begin
         failures++;
         $display("FAIL bp_setup: got G1=%0d BCNT=%0d expected 1 2", gnt1_a, bcnt_a);
      end
      for (int i = 0; i < 5; i++) begin
         drive(0, 1, 1, 0);
         checks++;
         if (beat_a !== 1'b0) begin
            failures++;
            $display("FAIL bp_beat%0d: got %0d expected 0", i, beat_a);
         end
         tick();
         checks++;
         if (gnt1_a !== 1'b1 || bcnt_a !== 8'd2) begin
            failures++;
            $display("FAIL bp_hold%0d: got G1=%0d BCNT=%0d expected 1 2", i, gnt1_a, bcnt_a);
         end
      end
      drive(0, 1, 1, 1); tick();
      checks++;
      if (gnt1_a !== 1'b1 || bcnt_a !== 8'd3) begin
         failures++;
         $display("FAIL bp_resume: got G1=%0d BCNT=%0d expected 1 3", gnt1_a, bcnt_a);
      end
      tick();
      checks++;
      if (gnt2_a !== 1'b1 || s_a !== 1'b1 || bcnt_a !== 8'd0) begin
         failures++;
         $display("FAIL bp_done: got G2=%0d S=%0d BCNT=%0d expected 1 1 0", gnt2_a, s_a, bcnt_a);
      end
   endtask

   task automatic test_early_release();
      drive(1, 0, 0, 0); tick();
      drive(0, 1, 0, 1); tick(); tick();
      checks++;
      if (bcnt_a !== 8'd1) begin
         failures++;
         $display("FAIL er_setup: got BCNT=%0d expected 1", bcnt_a);
      end
      drive(0, 0, 0, 1); tick();
      checks++;
      if (gnt1_a !== 1'b0 || gnt2_a !== 1'b0 || s_a !== 1'b0 || bcnt_a !== 8'd0) begin
         failures++;
         $display("FAIL er_idle: got G1=%0d G2=%0d S=%0d BCNT=%0d expected 0 0 0 0", gnt1_a, gnt2_a, s_a, bcnt_a);
      end
      drive(0, 0, 1, 1); tick();
      checks++;
      if (gnt2_a !== 1'b1 || s_a !== 1'b1) begin
         failures++;
         $display("FAIL er_grant2: got G2=%0d S=%0d expected 1 1", gnt2_a, s_a);
      end
      drive(0, 0, 0, 1); tick();
      checks++;
      if (gnt2_a !== 1'b0 || s_a !== 1'b1) begin
         failures++;
         $display("FAIL er_s_hold: got G2=%0d S=%0d expected 0 1", gnt2_a, s_a);
      end
   endtask

   task automatic test_regrant();
      drive(1, 0, 0, 0); tick();
      drive(0, 1, 0, 1); tick();
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (gnt1_a !== 1'b1 || bcnt_a !== 8'(i % 4)) begin
            failures++;
            $display("FAIL regrant%0d: got G1=%0d BCNT=%0d expected 1 %0d", i, gnt1_a, bcnt_a, i % 4);
         end
         tick();
      end
   endtask

   task automatic test_mid_reset();
      drive(1, 0, 0, 0); tick();
      drive(0, 0, 1, 1); tick(); tick(); tick(); tick();
      checks++;
      if (gnt2_a !== 1'b1 || bcnt_a !== 8'd3) begin
         failures++;
         $display("FAIL mr_setup: got G2=%0d BCNT=%0d expected 1 3", gnt2_a, bcnt_a);
      end
      drive(1, 0, 1, 1); tick();
      checks++;
      if (s_a !== 1'b0 || gnt1_a !== 1'b0 || gnt2_a !== 1'b0 || bcnt_a !== 8'd0 || beat_a !== 1'b0) begin
         failures++;
         $display("FAIL mr_reset: got S=%0d G1=%0d G2=%0d BCNT=%0d BEAT=%0d expected 0 0 0 0 0",
                  s_a, gnt1_a, gnt2_a, bcnt_a, beat_a);
      end
      drive(0, 1, 1, 1); tick();
      checks++;
      if (gnt1_a !== 1'b1 || s_a !== 1'b0) begin
         failures++;
         $display("FAIL mr_first: got G1=%0d S=%0d expected 1 0", gnt1_a, s_a);
      end
   endtask

   task automatic test_burst1();
      drive(1, 0, 0, 0); tick();
      drive(0, 1, 1, 1); tick();
      checks++;
      if (gnt1_b !== 1'b1 || s_b !== 1'b0) begin
         failures++;
         $display("FAIL b1_grant: got G1=%0d S=%0d expected 1 0", gnt1_b, s_b);
      end
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (beat_b !== 1'b1) begin
            failures++;
            $display("FAIL b1_beat%0d: got %0d expected 1", i, beat_b);
         end
         tick();
         checks++;
         if (s_b !== logic'((i + 1) % 2) || bcnt_b !== 8'd0) begin
            failures++;
            $display("FAIL b1_sel%0d: got S=%0d BCNT=%0d expected %0d 0", i, s_b, bcnt_b, (i + 1) % 2);
         end
      end
   endtask

   task automatic test_random();
      logic r1, r2;
      r1 = 1'b0; r2 = 1'b0;
      drive(1, 0, 0, 0); tick();
      for (int i = 0; i < 600; i++) begin
         if ($urandom % 6 == 0) r1 = ~r1;
         if ($urandom % 6 == 0) r2 = ~r2;
         drive(($urandom % 64) == 0, r1, r2, ($urandom % 4) != 0);
         checks++;
         if (beat_a !== m_beat(0) || beat_b !== m_beat(1)) begin
            failures++;
            $display("FAIL rnd_beat%0d: got %0d/%0d expected %0d/%0d", i, beat_a, beat_b, m_beat(0), m_beat(1));
         end
         tick();
         checks++;
         if (s_a !== logic'(m_sel[0]) || gnt1_a !== (m_own[0] == 1) || gnt2_a !== (m_own[0] == 2) ||
             bcnt_a !== 8'(m_cnt[0])) begin
            failures++;
            $display("FAIL rnd_a%0d: got S=%0d G1=%0d G2=%0d BCNT=%0d expected S=%0d owner=%0d BCNT=%0d",
                     i, s_a, gnt1_a, gnt2_a, bcnt_a, m_sel[0], m_own[0], m_cnt[0]);
         end
         checks++;
         if (s_b !== logic'(m_sel[1]) || gnt1_b !== (m_own[1] == 1) || gnt2_b !== (m_own[1] == 2) ||
             bcnt_b !== 8'(m_cnt[1])) begin
            failures++;
            $display("FAIL rnd_b%0d: got S=%0d G1=%0d G2=%0d BCNT=%0d expected S=%0d owner=%0d BCNT=%0d",
                     i, s_b, gnt1_b, gnt2_b, bcnt_b, m_sel[1], m_own[1], m_cnt[1]);
         end
      end
   endtask

   initial begin
      bl[0] = 4; bl[1] = 1;
      for (int k = 0; k < 2; k++) begin
         m_own[k] = 0; m_cnt[k] = 0; m_last[k] = 2; m_sel[k] = 0;
      end
      rst = 1'b1; req1 = 1'b0; req2 = 1'b0; ready = 1'b0;
      test_reset();
      test_first_tie();
      test_backpressure();
      test_early_release();
      test_regrant();
      test_mid_reset();
      test_burst1();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
